booth16_seq_ctrl: RTL and testbench

Sequencing controller for the radix-16 Booth sequential multiplier datapath.
- Accepts a multiplier operand through a valid/ready handshake and recodes it into WIDTH/4 signed radix-16 Booth digits, one per cycle.
- Drives the partial-product shift register's load (clear) input.
- Signals when the accumulated product is valid, so a downstream result register captures it before the shift register moves on.

---
 rtl/booth16_seq_if.sv | 51 +++++
 rtl/booth16_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_booth16_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth16_seq_if.sv
// Handshake and datapath-control bundle for booth16_seq_ctrl.
// The master side issues operands and accepts results. The slave side is the
// sequencing controller.
// When BOOTH_CTRL_ABORT_EN is defined, the bundle also carries the abort input.
interface booth16_seq_if #(
   parameter int WIDTH = 8
);
   localparam int STEPS = WIDTH / 4;
   localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;

   logic                    start_valid;
   logic                    start_ready;
   logic signed [WIDTH-1:0] multiplier;
   logic                    pp_load;
   logic                    digit_valid;
   logic [3:0]              digit_mag;
   logic                    digit_neg;
   logic [IDXW-1:0]         step_idx;
   logic                    last_step;
   logic                    prod_capture;
   logic                    res_valid;
   logic                    res_ready;
   logic                    busy;
`ifdef BOOTH_CTRL_ABORT_EN
   logic                    abort;

   modport master (
      output start_valid, multiplier, res_ready, abort,
      input  start_ready, pp_load, digit_valid, digit_mag, digit_neg,
             step_idx, last_step, prod_capture, res_valid, busy
   );

   modport slave (
      input  start_valid, multiplier, res_ready, abort,
      output start_ready, pp_load, digit_valid, digit_mag, digit_neg,
             step_idx, last_step, prod_capture, res_valid, busy
   );
`else
   modport master (
      output start_valid, multiplier, res_ready,
      input  start_ready, pp_load, digit_valid, digit_mag, digit_neg,
             step_idx, last_step, prod_capture, res_valid, busy
   );

   modport slave (
      input  start_valid, multiplier, res_ready,
      output start_ready, pp_load, digit_valid, digit_mag, digit_neg,
             step_idx, last_step, prod_capture, res_valid, busy
   );
`endif
endinterface

// File: rtl/booth16_seq_ctrl.sv
// Sequencing controller for the radix-16 Booth sequential multiplier.
// The controller accepts a signed multiplier through a valid/ready handshake.
// It emits WIDTH/4 signed Booth digits (LSB first), one per cycle.
// It drives the partial-product shift register's clear strobe.
// It flags the single cycle in which that register holds the final product.
// Optional feature: define BOOTH_CTRL_ABORT_EN to add an abort input. Abort
// returns RUN/DONE to IDLE without ever raising prod_capture.
// WIDTH must be a multiple of 4 and at least 8, and it must match the bound
// interface's WIDTH.
module booth16_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   booth16_seq_if.slave bus
);

   localparam int STEPS = WIDTH / 4;
   localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(STEPS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   // Multiplier with an appended zero below the LSB. Its low five bits always
   // hold the current overlapping Booth window b4..b0.
   logic signed [WIDTH:0] mreg;
   logic [IDXW-1:0]       cnt;
   // Set only while sitting in the first DONE cycle of a completed operation.
   logic                  cap_first;
   logic                  accept;
   logic                  kill;
   logic                  in_run;
   logic                  at_last;
   logic signed [4:0]     digit;

   // Radix-16 Booth digit: -8*b4 + 4*b3 + 2*b2 + b1 + b0, range -8..+8.
   // {b4,b4,b3,b2,b1} read as 5-bit signed equals -8*b4 + 4*b3 + 2*b2 + b1.
   function automatic logic signed [4:0] booth_digit(input logic [4:0] win);
      logic signed [4:0] hi;
      logic signed [4:0] lo;
      hi = $signed({win[4], win[4], win[3], win[2], win[1]});
      lo = $signed({4'b0000, win[0]});
      return hi + lo;
   endfunction

   // Magnitude of a Booth digit. |d| <= 8 always fits in four bits.
   function automatic logic [3:0] digit_abs(input logic signed [4:0] d);
      logic signed [4:0] m;
      m = (d < 0) ? -d : d;
      return m[3:0];
   endfunction

   assign accept  = (state == IDLE) && bus.start_valid;
   assign in_run  = (state == RUN);
   assign at_last = (cnt == LAST_IDX);
   assign digit   = booth_digit(mreg[4:0]);

`ifdef BOOTH_CTRL_ABORT_EN
   assign kill = bus.abort && (state != IDLE);
`else
   assign kill = 1'b0;
`endif

   // Next-state selection. Abort wins over completion and over res_ready.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN: begin
            if (kill)         state_nxt = IDLE;
            else if (at_last) state_nxt = DONE;
         end
         DONE: begin
            if (kill || bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and first-DONE-cycle marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cap_first <= 1'b0;
      end else begin
         state     <= state_nxt;
         cap_first <= in_run && at_last && !kill;
      end
   end

   // Operand window and digit counter. Load on handshake, then step 4 bits per digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mreg <= '0;
         cnt  <= '0;
      end else if (accept) begin
         mreg <= {bus.multiplier, 1'b0};
         cnt  <= '0;
      end else if (in_run) begin
         mreg <= mreg >>> 4;
         cnt  <= cnt + 1'b1;
      end
   end

   // Output decode. Digit fields are forced to zero outside RUN.
   always_comb begin
      bus.start_ready  = (state == IDLE);
      bus.busy         = (state != IDLE);
      bus.digit_valid  = in_run;
      bus.digit_mag    = in_run ? digit_abs(digit) : 4'd0;
      bus.digit_neg    = in_run && (digit < 0);
      bus.step_idx     = in_run ? cnt : '0;
      bus.last_step    = in_run && at_last;
      bus.res_valid    = (state == DONE);
      bus.prod_capture = (state == DONE) && cap_first && !kill;
      bus.pp_load      = (state == IDLE) || ((state == DONE) && !cap_first);
   end

endmodule

// File: tb/tb_booth16_seq_ctrl.sv
// Scoreboard bench for booth16_seq_ctrl: one WIDTH=8 and one WIDTH=16 instance.
// Stimulus pushes hand-computed Booth digits and capture expectations.
// Per-instance monitors pop and compare whenever a digit or capture appears.
module tb_booth16_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   booth16_seq_if #(.WIDTH(8))  b8 ();
   booth16_seq_if #(.WIDTH(16)) b16 ();

   booth16_seq_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   booth16_seq_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

   typedef struct {
      logic [3:0] mag;
      logic       neg;
      int         idx;
      logic       last;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   int   cap8 = 0;
   int   cap16 = 0;
   int   errors = 0;
   int   checks = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endfunction

   function automatic void chk_rst8(input string tag);
      chk({tag, "8_start_ready"}, b8.start_ready, 1);
      chk({tag, "8_pp_load"}, b8.pp_load, 1);
      chk({tag, "8_digit_valid"}, b8.digit_valid, 0);
      chk({tag, "8_digit"}, {b8.digit_mag, b8.digit_neg, b8.step_idx, b8.last_step}, 0);
      chk({tag, "8_capture"}, b8.prod_capture, 0);
      chk({tag, "8_res_valid"}, b8.res_valid, 0);
      chk({tag, "8_busy"}, b8.busy, 0);
   endfunction

   function automatic void chk_rst16(input string tag);
      chk({tag, "16_start_ready"}, b16.start_ready, 1);
      chk({tag, "16_pp_load"}, b16.pp_load, 1);
      chk({tag, "16_digit_valid"}, b16.digit_valid, 0);
      chk({tag, "16_digit"}, {b16.digit_mag, b16.digit_neg, b16.step_idx, b16.last_step}, 0);
      chk({tag, "16_capture"}, b16.prod_capture, 0);
      chk({tag, "16_res_valid"}, b16.res_valid, 0);
      chk({tag, "16_busy"}, b16.busy, 0);
   endfunction

   function automatic void push8(input logic [3:0] mag0, input logic neg0,
                                 input logic [3:0] mag1, input logic neg1);
      exp_t e;
      e.mag = mag0; e.neg = neg0; e.idx = 0; e.last = 1'b0; q8.push_back(e);
      e.mag = mag1; e.neg = neg1; e.idx = 1; e.last = 1'b1; q8.push_back(e);
   endfunction

   // mags holds idx0 in bits [3:0] up to idx3 in bits [15:12]; negs[i] is the sign of idx i.
   function automatic void push16(input logic [15:0] mags, input logic [3:0] negs);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.mag  = mags[4*i +: 4];
         e.neg  = negs[i];
         e.idx  = i;
         e.last = (i == 3);
         q16.push_back(e);
      end
   endfunction

   // Monitor for the 8-bit instance.
   always @(negedge clk) begin : mon8
      exp_t e;
      if (rst_n) begin
         if (b8.digit_valid) begin
            if (q8.size() == 0) begin
               checks++; errors++;
               $display("FAIL digit8_spurious: got digit mag=%0d idx=%0d, expected no digit", b8.digit_mag, b8.step_idx);
            end else begin
               e = q8.pop_front();
               chk("digit8_mag", b8.digit_mag, e.mag);
               chk("digit8_neg", b8.digit_neg, e.neg);
               chk("digit8_idx", b8.step_idx, e.idx);
               chk("digit8_last", b8.last_step, e.last);
               chk("digit8_pp_load", b8.pp_load, 0);
            end
         end
         if (b8.prod_capture) begin
            checks++;
            if (cap8 == 0) begin
               errors++;
               $display("FAIL capture8_spurious: got prod_capture=1, expected 0");
            end else cap8--;
            chk("capture8_res_valid", b8.res_valid, 1);
            chk("capture8_pp_load", b8.pp_load, 0);
         end
      end
   end

   // Monitor for the 16-bit instance.
   always @(negedge clk) begin : mon16
      exp_t e;
      if (rst_n) begin
         if (b16.digit_valid) begin
            if (q16.size() == 0) begin
               checks++; errors++;
               $display("FAIL digit16_spurious: got digit mag=%0d idx=%0d, expected no digit", b16.digit_mag, b16.step_idx);
            end else begin
               e = q16.pop_front();
               chk("digit16_mag", b16.digit_mag, e.mag);
               chk("digit16_neg", b16.digit_neg, e.neg);
               chk("digit16_idx", b16.step_idx, e.idx);
               chk("digit16_last", b16.last_step, e.last);
            end
         end
         if (b16.prod_capture) begin
            checks++;
            if (cap16 == 0) begin
               errors++;
               $display("FAIL capture16_spurious: got prod_capture=1, expected 0");
            end else cap16--;
            chk("capture16_res_valid", b16.res_valid, 1);
         end
      end
   end

   // Issue one 8-bit op from a negedge, wait (bounded) for the result and accept it.
   task automatic run8(input logic [7:0] m);
      int n;
      cap8++;
      chk("run8_start_ready", b8.start_ready, 1);
      b8.multiplier  = m;
      b8.start_valid = 1'b1;
      @(posedge clk); #1;
      b8.start_valid = 1'b0;
      b8.multiplier  = 8'hA5;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!b8.res_valid && n < 12);
      chk("run8_res_valid", b8.res_valid, 1);
      b8.res_ready = 1'b1;
      @(negedge clk);
      b8.res_ready = 1'b0;
      chk("run8_back_idle", b8.start_ready, 1);
   endtask

   task automatic run16(input logic [15:0] m);
      int n;
      cap16++;
      chk("run16_start_ready", b16.start_ready, 1);
      b16.multiplier  = m;
      b16.start_valid = 1'b1;
      @(posedge clk); #1;
      b16.start_valid = 1'b0;
      b16.multiplier  = 16'h5A5A;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!b16.res_valid && n < 16);
      chk("run16_res_valid", b16.res_valid, 1);
      b16.res_ready = 1'b1;
      @(negedge clk);
      b16.res_ready = 1'b0;
      chk("run16_back_idle", b16.start_ready, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      b8.start_valid  = 1'b0; b8.multiplier  = '0; b8.res_ready  = 1'b0;
      b16.start_valid = 1'b0; b16.multiplier = '0; b16.res_ready = 1'b0;
`ifdef BOOTH_CTRL_ABORT_EN
      b8.abort = 1'b0; b16.abort = 1'b0;
`endif

      // Reset values while held in reset, then after release and 3 idle cycles.
      repeat (3) @(negedge clk);
      chk_rst8("rst");
      chk_rst16("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_rst8("idle");
      chk_rst16("idle");

      // 8'h7F with cycle-exact timing; result accepted in the first DONE cycle.
      push8(4'd1, 1'b1, 4'd8, 1'b0);
      cap8++;
      b8.multiplier  = 8'h7F;
      b8.start_valid = 1'b1;
      chk("t2_start_ready", b8.start_ready, 1);
      @(posedge clk); #1;
      b8.start_valid = 1'b0;
      @(negedge clk);
      chk("t2_c1_busy", b8.busy, 1);
      chk("t2_c1_start_ready", b8.start_ready, 0);
      chk("t2_c1_digit_valid", b8.digit_valid, 1);
      @(negedge clk);
      chk("t2_c2_res_valid", b8.res_valid, 0);
      @(negedge clk);
      chk("t2_c3_capture", b8.prod_capture, 1);
      chk("t2_c3_res_valid", b8.res_valid, 1);
      chk("t2_c3_pp_load", b8.pp_load, 0);
      chk("t2_c3_digit_valid", b8.digit_valid, 0);
      b8.res_ready = 1'b1;
      @(negedge clk);
      b8.res_ready = 1'b0;
      chk("t2_c4_res_valid", b8.res_valid, 0);
      chk("t2_c4_start_ready", b8.start_ready, 1);
      chk("t2_c4_pp_load", b8.pp_load, 1);

      // Most negative and all-ones operands.
      push8(4'd0, 1'b0, 4'd8, 1'b1);
      run8(8'h80);
      push8(4'd1, 1'b1, 4'd0, 1'b0);
      run8(8'hFF);

      // Hold DONE for 5 cycles with res_ready low and start pulses arriving.
      push8(4'd2, 1'b0, 4'd1, 1'b0);
      cap8++;
      b8.multiplier  = 8'h12;
      b8.start_valid = 1'b1;
      @(posedge clk); #1;
      b8.start_valid = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_res_valid", b8.res_valid, 1);
         chk("t4_capture", b8.prod_capture, (k == 0));
         chk("t4_pp_load", b8.pp_load, (k != 0));
         chk("t4_start_ready", b8.start_ready, 0);
         b8.start_valid = (k >= 1);
         b8.multiplier  = 8'h55;
      end
      b8.start_valid = 1'b0;
      b8.res_ready   = 1'b1;
      @(negedge clk);
      b8.res_ready = 1'b0;
      chk("t4_after_res_valid", b8.res_valid, 0);
      chk("t4_after_start_ready", b8.start_ready, 1);
      @(negedge clk);
      chk("t4_no_queued_op", b8.digit_valid, 0);

      // 16-bit: 16'h1234 gives +4,+3,+2,+1.
      push16(16'h1234, 4'b0000);
      run16(16'h1234);

      // Reset asserted during idx 1 of a second op.
      push16(16'h0001, 4'b0001);
      b16.multiplier  = 16'hFFFF;
      b16.start_valid = 1'b1;
      @(posedge clk); #1;
      b16.start_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      chk("t5_pre_rst_idx", b16.step_idx, 1);
      rst_n = 1'b0;
      #1;
      chk_rst16("midrst");
      q16.delete();
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_rst16("postrst");
      // Most negative 16-bit value: 0, 0, 0, -8.
      push16(16'h8000, 4'b1000);
      run16(16'h8000);

`ifdef BOOTH_CTRL_ABORT_EN
      // Abort at RUN idx 0, then a clean op on 8'h01.
      begin
         exp_t e;
         e.mag = 4'd1; e.neg = 1'b1; e.idx = 0; e.last = 1'b0;
         q8.push_back(e);
      end
      b8.multiplier  = 8'h7F;
      b8.start_valid = 1'b1;
      @(posedge clk); #1;
      b8.start_valid = 1'b0;
      b8.abort       = 1'b1;
      @(posedge clk); #1;
      b8.abort = 1'b0;
      @(negedge clk);
      chk("t6_digit_valid", b8.digit_valid, 0);
      chk("t6_res_valid", b8.res_valid, 0);
      chk("t6_capture", b8.prod_capture, 0);
      chk("t6_pp_load", b8.pp_load, 1);
      chk("t6_start_ready", b8.start_ready, 1);
      repeat (3) @(negedge clk);
      chk("t6_still_idle", b8.res_valid, 0);
      push8(4'd1, 1'b0, 4'd0, 1'b0);
      run8(8'h01);
`endif

      repeat (3) @(negedge clk);
      chk("end_q8_empty", q8.size(), 0);
      chk("end_q16_empty", q16.size(), 0);
      chk("end_cap8_done", cap8, 0);
      chk("end_cap16_done", cap16, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
